// File: rtl/psi_fifo_drain.sv
// psi_fifo_drain: Avalon-MM master that drains the PSI filter packet FIFO onto a valid/ready stream.
// Optional list-number filtering is compiled in when PSI_DRAIN_LIST_FILTER_EN is defined.
module psi_fifo_drain #(
    parameter int                    ADDR_WIDTH    = 12,
    parameter logic [ADDR_WIDTH-1:0] DATA_ADDR     = 12'h314,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR   = 12'h315,
    parameter logic [ADDR_WIDTH-1:0] CLEAR_ADDR    = 12'h316,
    parameter int                    WORDS_PER_PKT = 96,
    parameter int                    POLL_INTERVAL = 64,
    parameter int                    TIMEOUT       = 1023
) (
    input  logic                  avalon_clk,
    input  logic                  avalon_rst,
    input  logic                  enable,
    input  logic                  irq_in,
    input  logic                  flush_req,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic                  m_read,
    output logic                  m_write,
    output logic [15:0]           m_writedata,
    input  logic [15:0]           m_readdata,
    input  logic                  m_waitrequest,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [15:0]           out_data,
    output logic [15:0]           out_listnum,
    output logic [15:0]           pkt_count,
`ifdef PSI_DRAIN_LIST_FILTER_EN
    input  logic [15:0]           list_mask,
    output logic [15:0]           drop_count,
`endif
    output logic                  err_timeout
);

    localparam int IDX_W   = $clog2(WORDS_PER_PKT);
    localparam int TMR_W   = $clog2(POLL_INTERVAL + 1);
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_PKT - 1);

    typedef enum logic [2:0] {
        IDLE, POLL_RD, EVAL, DATA_RD, PUSH, GAP, FLUSH
    } state_t;

    state_t             state, state_next;
    state_t             gap_target, gap_target_next;
    logic [IDX_W-1:0]   index;
    logic [3:0]         level;
    logic [TMR_W-1:0]   timer;
    logic [STALL_W-1:0] stall;
    logic               flush_pend;
    logic               drop_pkt;
    logic               drop_now;
    logic               rd_state, timed_out, rd_done, last_half, accept;

    assign rd_state  = (state == POLL_RD) || (state == DATA_RD);
    assign timed_out = rd_state && (stall >= STALL_W'(TIMEOUT));
    assign rd_done   = rd_state && !timed_out && !m_waitrequest;
    assign last_half = (index == LAST_IDX);
    // A dropped packet still walks through PUSH, but never waits on the sink.
    assign accept    = (state == PUSH) && (out_ready || drop_pkt);

`ifdef PSI_DRAIN_LIST_FILTER_EN
    assign drop_now = (m_readdata[15:4] != 12'h000) || !list_mask[m_readdata[3:0]];
`else
    assign drop_now = 1'b0;
`endif

    assign out_valid   = (state == PUSH) && !drop_pkt;
    assign out_sop     = out_valid && (index == '0);
    assign out_eop     = out_valid && last_half;
    assign m_writedata = 16'h0000;

    always_ff @(posedge avalon_clk or posedge avalon_rst) begin
        if (avalon_rst) begin
            state      <= IDLE;
            gap_target <= IDLE;
        end else begin
            state      <= state_next;
            gap_target <= gap_target_next;
        end
    end

    always_comb begin
        state_next      = state;
        gap_target_next = gap_target;
        m_address       = STATUS_ADDR;
        m_read          = 1'b0;
        m_write         = 1'b0;
        case (state)
            IDLE: begin
                if (flush_pend)
                    state_next = FLUSH;
                else if (enable && (irq_in || timer == TMR_W'(POLL_INTERVAL)))
                    state_next = POLL_RD;
            end
            POLL_RD: begin
                m_read = !timed_out;
                if (timed_out)
                    state_next = FLUSH;
                else if (!m_waitrequest)
                    state_next = EVAL;
            end
            EVAL: begin
                state_next = (level == 4'd0) ? IDLE : DATA_RD;
            end
            DATA_RD: begin
                m_address = DATA_ADDR;
                m_read    = !timed_out;
                if (timed_out)
                    state_next = FLUSH;
                else if (!m_waitrequest)
                    state_next = PUSH;
            end
            PUSH: begin
                if (accept) begin
                    state_next = GAP;
                    if (!last_half)
                        gap_target_next = DATA_RD;
                    else if (enable && !flush_pend)
                        gap_target_next = POLL_RD;
                    else
                        gap_target_next = IDLE;
                end
            end
            GAP: begin
                state_next = gap_target;
            end
            FLUSH: begin
                m_address       = CLEAR_ADDR;
                m_write         = 1'b1;
                state_next      = GAP;
                gap_target_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // flush_pend starts set so the filter FIFO is cleared once after reset.
    always_ff @(posedge avalon_clk or posedge avalon_rst) begin
        if (avalon_rst) begin
            index       <= '0;
            level       <= '0;
            timer       <= '0;
            stall       <= '0;
            flush_pend  <= 1'b1;
            drop_pkt    <= 1'b0;
            out_data    <= '0;
            out_listnum <= '0;
            pkt_count   <= '0;
            err_timeout <= 1'b0;
`ifdef PSI_DRAIN_LIST_FILTER_EN
            drop_count  <= '0;
`endif
        end else begin
            if (state != IDLE)
                timer <= '0;
            else if (enable)
                timer <= timer + TMR_W'(1);

            if (rd_state && m_waitrequest && !timed_out)
                stall <= stall + STALL_W'(1);
            else
                stall <= '0;

            if (state == FLUSH)
                flush_pend <= 1'b0;
            if (flush_req)
                flush_pend <= 1'b1;

            if (state == POLL_RD && rd_done)
                level <= m_readdata[3:0];

            if (state == EVAL || state == FLUSH)
                index <= '0;
            else if (accept)
                index <= last_half ? '0 : index + IDX_W'(1);

            if (state == FLUSH)
                drop_pkt <= 1'b0;

            if (state == DATA_RD && rd_done) begin
                out_data <= m_readdata;
                if (index == '0) begin
                    drop_pkt <= drop_now;
                    if (!drop_now)
                        out_listnum <= m_readdata;
                end
`ifdef PSI_DRAIN_LIST_FILTER_EN
                if (last_half && drop_pkt)
                    drop_count <= drop_count + 16'd1;
`endif
            end

            if (accept && last_half && !drop_pkt)
                pkt_count <= pkt_count + 16'd1;

            if (timed_out)
                err_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_psi_fifo_drain.sv
// tb_psi_fifo_drain: directed and randomized bench for psi_fifo_drain with an Avalon slave FIFO
// model and a packet-level stream scoreboard.
module tb_psi_fifo_drain;

    localparam logic [11:0] DATA_ADDR   = 12'h314;
    localparam logic [11:0] STATUS_ADDR = 12'h315;
    localparam logic [11:0] CLEAR_ADDR  = 12'h316;
    localparam int          WPP         = 96;

    typedef struct {
        logic [15:0] data;
        logic        sop;
        logic        eop;
        logic [15:0] listnum;
    } beat_t;

    logic        avalon_clk = 1'b0;
    logic        avalon_rst = 1'b1;
    logic        enable = 1'b0, irq_in = 1'b0, flush_req = 1'b0;
    logic [11:0] m_address;
    logic        m_read, m_write;
    logic [15:0] m_writedata;
    logic [15:0] m_readdata = 16'h0000;
    logic        m_waitrequest = 1'b0;
    logic        out_valid, out_sop, out_eop;
    logic        out_ready = 1'b1;
    logic [15:0] out_data, out_listnum, pkt_count;
    logic        err_timeout;
`ifdef PSI_DRAIN_LIST_FILTER_EN
    logic [15:0] list_mask = 16'hFFFF;
    logic [15:0] drop_count;
`endif

    logic [15:0] fifo_q[$];
    beat_t       exp_q[$];
    int checks = 0, errors = 0;
    int beats = 0, data_reads = 0, polls = 0, writes = 0;
    int exp_pkts = 0, exp_drops = 0;
    bit random_wait = 0, random_ready = 0, stall_hold = 0, prev_done = 0;

    psi_fifo_drain dut (
        .avalon_clk(avalon_clk), .avalon_rst(avalon_rst), .enable(enable), .irq_in(irq_in),
        .flush_req(flush_req), .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest),
        .out_valid(out_valid), .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
        .out_data(out_data), .out_listnum(out_listnum), .pkt_count(pkt_count),
`ifdef PSI_DRAIN_LIST_FILTER_EN
        .list_mask(list_mask), .drop_count(drop_count),
`endif
        .err_timeout(err_timeout)
    );

    always #5 avalon_clk = ~avalon_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge avalon_clk);
        #2;
    endtask

    task automatic applyStimulus(input logic en, input logic irq, input logic flush);
        @(posedge avalon_clk);
        #1;
        enable    = en;
        irq_in    = irq;
        flush_req = flush;
    endtask

    task automatic loadPacket(input logic [15:0] listnum, input bit fwd);
        for (int i = 0; i < WPP; i++) begin
            logic [15:0] h;
            h = (i == 0) ? listnum : 16'($urandom);
            fifo_q.push_back(h);
            if (fwd)
                exp_q.push_back('{data: h, sop: (i == 0), eop: (i == WPP - 1), listnum: listnum});
        end
        if (fwd) exp_pkts++;
        else     exp_drops++;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() > 0 || fifo_q.size() > 0) && n < 5000) begin
            waitCycles(1);
            n++;
        end
        waitCycles(4);
        checkOutput(tag, 32'(exp_q.size() + fifo_q.size()), 32'd0);
    endtask

    // Slave side: the filter's registers, answering by address with a randomizable waitrequest.
    always @(posedge avalon_clk) begin
        int lv;
        #1;
        m_waitrequest = stall_hold || (random_wait && ($urandom_range(0, 3) == 0));
        if (random_ready) out_ready = ($urandom_range(0, 2) != 0);
        lv = fifo_q.size() / WPP;
        if (lv > 15) lv = 15;
        if (m_address == DATA_ADDR)
            m_readdata = (fifo_q.size() > 0) ? fifo_q[0] : 16'hDEAD;
        else
            m_readdata = 16'(lv);
    end

    // Bus and stream monitor: consumes completed transfers and scoreboards every accepted beat.
    always @(negedge avalon_clk) begin
        beat_t e;
        if (!avalon_rst) begin
            if (prev_done) checkOutput("read_gap", 32'(m_read), 32'd0);
            prev_done = m_read && !m_waitrequest;
            if (m_read && !m_waitrequest) begin
                if (m_address == DATA_ADDR) begin
                    data_reads++;
                    if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                end else begin
                    polls++;
                    checkOutput("poll_addr", 32'(m_address), 32'(STATUS_ADDR));
                end
            end
            if (m_write) begin
                writes++;
                checkOutput("clear_addr", 32'(m_address), 32'(CLEAR_ADDR));
                checkOutput("clear_data", 32'(m_writedata), 32'd0);
                checkOutput("clear_mid_pkt", 32'(exp_q.size()), 32'd0);
                fifo_q.delete();
            end
            if (out_valid && out_ready) begin
                beats++;
                checkOutput("beat_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("beat", {14'd0, out_sop, out_eop, out_data}, {14'd0, e.sop, e.eop, e.data});
                    if (e.sop) checkOutput("listnum", 32'(out_listnum), 32'(e.listnum));
                end
            end
        end
    end

    initial begin
        int n, p0, dr0, w0;
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, p0, dr0, w0;
        // Reset values
        waitCycles(3);
        checkOutput("rst_read",    32'(m_read), 32'd0);
        checkOutput("rst_write",   32'(m_write), 32'd0);
        checkOutput("rst_addr",    32'(m_address), 32'(STATUS_ADDR));
        checkOutput("rst_valid",   32'(out_valid), 32'd0);
        checkOutput("rst_pkts",    32'(pkt_count), 32'd0);
        checkOutput("rst_listnum", 32'(out_listnum), 32'd0);
        checkOutput("rst_err",     32'(err_timeout), 32'd0);
        @(posedge avalon_clk); #1 avalon_rst = 1'b0;
        n = 0;
        while (writes == 0 && n < 10) begin waitCycles(1); n++; end
        waitCycles(5);
        checkOutput("reset_flush", 32'(writes), 32'd1);

        // One packet, level=1
        applyStimulus(1'b1, 1'b0, 1'b0);
        loadPacket(16'($urandom_range(0, 15)), 1'b1);
        drain("drain_t1");
        checkOutput("t1_pkts",  32'(pkt_count), 32'(exp_pkts));
        checkOutput("t1_reads", 32'(data_reads), 32'(WPP));

        // Back-pressure on half-word 7 with random waitrequest
        random_wait = 1;
        n = beats;
        loadPacket(16'($urandom_range(0, 15)), 1'b1);
        p0 = 0;
        while (beats < n + 7 && p0 < 2000) begin waitCycles(1); p0++; end
        out_ready = 1'b0;
        p0 = 0;
        while (!out_valid && p0 < 200) begin waitCycles(1); p0++; end
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_read",  32'(m_read), 32'd0);
            checkOutput("bp_data",  32'(out_data), 32'(exp_q[0].data));
            waitCycles(1);
        end
        out_ready = 1'b1;
        drain("drain_t2");
        random_wait = 0;
        checkOutput("t2_pkts",  32'(pkt_count), 32'(exp_pkts));
        checkOutput("t2_reads", 32'(data_reads), 32'(2 * WPP));

        // irq_in in IDLE with an empty FIFO
        waitCycles(10);
        p0 = polls;
        dr0 = data_reads;
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("irq_read", 32'(m_read), 32'd1);
        checkOutput("irq_addr", 32'(m_address), 32'(STATUS_ADDR));
        waitCycles(5);
        checkOutput("irq_polls", 32'(polls), 32'(p0 + 1));
        checkOutput("irq_noread", 32'(data_reads), 32'(dr0));
        checkOutput("irq_idle", 32'(m_read), 32'd0);

        // flush_req at half-word 40 must not truncate the packet
        w0 = writes;
        n = beats;
        loadPacket(16'($urandom_range(0, 15)), 1'b1);
        p0 = 0;
        while (beats < n + 40 && p0 < 2000) begin waitCycles(1); p0++; end
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        drain("drain_t4");
        waitCycles(10);
        checkOutput("t4_pkts", 32'(pkt_count), 32'(exp_pkts));
        checkOutput("t4_one_clear", 32'(writes), 32'(w0 + 1));

        // Read stall timeout
        w0 = writes;
        stall_hold = 1;
        waitCycles(2);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        #1;
        n = 0;
        while (m_read && n < 1100) begin n++; waitCycles(1); end
        checkOutput("timeout_cycles", 32'(n), 32'd1023);
        waitCycles(1);
        checkOutput("timeout_err",   32'(err_timeout), 32'd1);
        checkOutput("timeout_flush", 32'(m_write), 32'd1);
        stall_hold = 0;
        waitCycles(3);
        checkOutput("timeout_clears", 32'(writes), 32'(w0 + 1));

`ifdef PSI_DRAIN_LIST_FILTER_EN
        // List filtering: listnum 2 forwarded, listnum 3 dropped
        list_mask = 16'h0004;
        loadPacket(16'h0002, 1'b1);
        loadPacket(16'h0003, 1'b0);
        drain("drain_t6");
        checkOutput("t6_pkts",    32'(pkt_count), 32'(exp_pkts));
        checkOutput("t6_drops",   32'(drop_count), 32'(exp_drops));
        checkOutput("t6_listnum", 32'(out_listnum), 32'h0002);
        list_mask = 16'hFFFF;
`endif

        // Randomized: three queued packets, random waitrequest and back-pressure
        random_wait  = 1;
        random_ready = 1;
        for (int k = 0; k < 3; k++) loadPacket(16'($urandom_range(0, 15)), 1'b1);
        drain("drain_t7");
        random_ready = 0;
        random_wait  = 0;
        out_ready    = 1'b1;
        waitCycles(2);
        checkOutput("final_pkts", 32'(pkt_count), 32'(exp_pkts));
        checkOutput("final_err",  32'(err_timeout), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
